// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipeline_pkg;

  localparam int REG_W_DEF = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired to zero, so a load targeting it never feeds a consumer
  assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline control: stage enables/flushes for memory waits,
// branch redirects and load-use stalls, plus a saturating stall counter.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t state, state_n;
  logic   redir_pend, redir_n;
  logic   load_use;
  logic   dstall;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign dstall = dmem_req && !dmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      redir_pend <= 1'b0;
    end else begin
      state      <= state_n;
      redir_pend <= redir_n;
    end
  end

  always_comb begin
    state_n     = state;
    redir_n     = redir_pend;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      {ifid_flush, idex_flush, memwb_flush}         = '1;
      state_n = RUN;
      redir_n = 1'b0;
    end else if (dstall) begin
      // Whole pipe freezes; the bubble keeps WB from retiring twice
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      memwb_flush = 1'b1;
      state_n     = DWAIT;
    end else begin
      state_n = imem_ready ? RUN : IWAIT;
      if (ex_br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
      // A redirect taken while a fetch was outstanding leaves that fetch stale
      if (imem_ready) begin
        if (redir_pend) ifid_flush = 1'b1;
        redir_n = 1'b0;
      end else if (ex_br_taken) begin
        redir_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
